gimli_permutation_iterative: RTL and testbench
==============================================

// Module: gimli_permutation_iterative
// PURPOSE
//  Iterative full Gimli permutation wrapped around gimli_all_columns_non_linear_permutation.
//  - Holds the 384-bit state in a register.
//  - Each round applies the column SP-box layer, then the linear layer (small/big swap plus round constant).
//  - Loads from an upstream valid/ready source and presents the permuted state to a downstream valid/ready sink.
// PARAMETERS
//  ROUNDS   24   rounds per permutation, counted ROUNDS down to 1; must be a multiple of 4, >= 4
// PORTS
//  clk        in   1    single clock; all state changes on the rising edge
//  rst        in   1    synchronous, active-high reset
//  din        in   384  input state; word i = din[32i+31:32i]; rows x=w0..3, y=w4..7, z=w8..11
//  din_valid  in   1    upstream has a state on din
//  din_ready  out  1    block can accept din this cycle
//  dout       out  384  permuted state, same word layout as din
//  dout_valid out  1    dout holds a completed permutation
//  dout_ready in   1    downstream consumes dout this cycle
// BEHAVIOUR
//  FSM states: IDLE, BUSY, DONE.
//  - Reset: IDLE, round counter = 0, state register = 0, din_ready=1, dout_valid=0, dout=0.
//  IDLE:
//  - din_ready = 1.
//  - On din_valid: load the state register from din, set counter = ROUNDS, go to BUSY.
//  BUSY:
//  - din_ready = 0 and dout_valid = 0. din_valid is ignored.
//  - Each edge applies round r = counter to the state register, then decrements counter.
//  - Round r:
//    - SP-box on all 4 columns, using the gimli_all_columns_non_linear_permutation instance.
//    - If r%4==0: small swap (w0<->w1, w2<->w3), then w0 ^= 32'h9e377900 ^ r.
//    - If r%4==2: big swap (w0<->w2, w1<->w3).
//    - Otherwise: no linear step.
//  - The edge that applies r==1 moves the FSM to DONE.
//  DONE:
//  - dout_valid = 1; dout is stable and equals the state register.
//  - On dout_ready: go to IDLE.
//  - din_ready = 0. A new load is accepted only in IDLE, so there is no bypass.
//  Timing:
//  - Latency: dout_valid rises exactly ROUNDS cycles after the din accept edge.
//  - Throughput: one permutation per ROUNDS+2 cycles, with dout_ready held high.
//  - dout is driven from the state register at all times. It is meaningful only while dout_valid=1.
//  Arithmetic:
//  - Round constant: counter zero-extended to 32 bits before the XOR.
//  - Counter width: $clog2(ROUNDS+1).
//  Boundary conditions:
//  - rst high in any state (including mid-BUSY or DONE with dout_ready low): the next edge forces reset values; the partial state is discarded.
//  - rst has priority over every handshake.
//  - din_valid and dout_ready both high in DONE: only the dout handshake takes effect. din is taken in the following IDLE cycle if still valid.
//  - Downstream stall: dout_valid and dout stay held indefinitely. No overwrite, no timeout.
// CONFIGURATION
//  Macro: GIMLI_PERMUTATION_TWO_ROUNDS_PER_CYCLE_EN.
//  - Defined:
//    - Two rounds (r, then r-1) are chained per BUSY edge, using two SP-box layer instances.
//    - Counter decrements by 2; the edge that applies rounds 2 and 1 moves to DONE.
//    - Latency: ROUNDS/2 cycles.
//  - Undefined: one round per edge, as described above.
//  Results are bit-identical with and without the macro.
// TESTING
//  - Gimli paper vector: din word i = i*i*i + i*32'h9e3779b9.
//    -> dout w0=32'hba11c85a ... w11=32'hf41bb8d6.
//    -> dout_valid exactly 24 cycles after accept (12 with the macro).
//  - Backpressure: hold dout_ready=0 for 50 cycles in DONE.
//    -> dout_valid=1, dout constant, din_ready=0 throughout.
//    -> dout_ready=1 for one cycle -> IDLE, din_ready=1.
//  - Reset mid-operation: assert rst at round 10 of BUSY.
//    -> next cycle din_ready=1, dout_valid=0, dout=0.
//    -> a fresh run on the paper vector still gives 32'hba11c85a in w0.
//  - Busy-period input: toggle din_valid with random din during BUSY and DONE.
//    -> no effect on the result; the paper vector output is unchanged.
//  - Back-to-back: din_valid and dout_ready held high, din=all-zero.
//    -> successive results every ROUNDS+2 cycles, each equal to the all-zero-input reference model.
//  - ROUNDS=4, din=0 -> round-constant path exercised.
//    -> dout w0 matches the reference model, including the 32'h9e377904 constant.

Source files
------------

// File: rtl/gimli_permutation_iterative.sv
// Iterative Gimli permutation: 384-bit state register, one (or two) rounds per BUSY cycle.
// Optional macro GIMLI_PERMUTATION_TWO_ROUNDS_PER_CYCLE_EN chains two rounds per cycle.

module gimli_all_columns_non_linear_permutation (
  input  logic [383:0] state_i,
  output logic [383:0] state_o
);

  for (genvar j = 0; j < 4; j++) begin : g_col
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] x_s;
    logic [31:0] y_s;
    logic [31:0] z_s;

    assign a_s = state_i[32*j +: 32];
    assign b_s = state_i[128 + 32*j +: 32];
    // x = rotl(a, 24), y = rotl(b, 9)
    assign x_s = {a_s[7:0], a_s[31:8]};
    assign y_s = {b_s[22:0], b_s[31:23]};
    assign z_s = state_i[256 + 32*j +: 32];

    assign state_o[256 + 32*j +: 32] = x_s ^ (z_s << 2'd1) ^ ((y_s & z_s) << 2'd2);
    assign state_o[128 + 32*j +: 32] = y_s ^ x_s ^ ((x_s | z_s) << 2'd1);
    assign state_o[32*j +: 32]       = z_s ^ y_s ^ ((x_s & y_s) << 2'd3);
  end

endmodule

module gimli_permutation_iterative #(
  parameter int ROUNDS = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [383:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
`ifdef GIMLI_PERMUTATION_TWO_ROUNDS_PER_CYCLE_EN
  localparam logic [CW-1:0] STEP_C   = CW'(2);
`else
  localparam logic [CW-1:0] STEP_C   = ONE_C;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [383:0]  state_q, state_d;
  logic          din_ready_q;
  logic          dout_valid_q;

  logic [383:0]  sp_a_s;
  logic [383:0]  round_a_s;
  logic [383:0]  round_out_s;

  // Linear layer of round r: small swap + constant when r%4==0, big swap when r%4==2.
  function automatic logic [383:0] linear_layer(input logic [383:0] s, input logic [CW-1:0] r);
    logic [383:0] t;
    t = s;
    case (r[1:0])
      2'd0: begin
        t[31:0]   = s[63:32] ^ 32'h9e377900 ^ {{(32-CW){1'b0}}, r};
        t[63:32]  = s[31:0];
        t[95:64]  = s[127:96];
        t[127:96] = s[95:64];
      end
      2'd2: begin
        t[31:0]   = s[95:64];
        t[63:32]  = s[127:96];
        t[95:64]  = s[31:0];
        t[127:96] = s[63:32];
      end
      default: t = s;
    endcase
    return t;
  endfunction

  gimli_all_columns_non_linear_permutation u_sp_a (
    .state_i (state_q),
    .state_o (sp_a_s)
  );

  assign round_a_s = linear_layer(sp_a_s, cnt_q);

`ifdef GIMLI_PERMUTATION_TWO_ROUNDS_PER_CYCLE_EN
  logic [383:0] sp_b_s;

  gimli_all_columns_non_linear_permutation u_sp_b (
    .state_i (round_a_s),
    .state_o (sp_b_s)
  );

  assign round_out_s = linear_layer(sp_b_s, cnt_q - ONE_C);
`else
  assign round_out_s = round_a_s;
`endif

  // Next-state logic for the load / iterate / present sequence.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (din_valid) begin
          state_d = din;
          cnt_d   = ROUNDS_C;
          fsm_d   = BUSY;
        end else begin
          fsm_d   = IDLE;
        end
      end
      BUSY: begin
        state_d = round_out_s;
        cnt_d   = cnt_q - STEP_C;
        if (cnt_q == STEP_C) begin
          fsm_d = DONE;
        end else begin
          fsm_d = BUSY;
        end
      end
      DONE: begin
        if (dout_ready) begin
          fsm_d = IDLE;
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // State registers; handshake outputs are registered from the next FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      cnt_q        <= '0;
      state_q      <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      din_ready_q  <= (fsm_d == IDLE);
      dout_valid_q <= (fsm_d == DONE);
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = state_q;

endmodule

// File: tb/tb_gimli_permutation_iterative.sv
// Directed bench for gimli_permutation_iterative: paper vector, backpressure, reset,
// busy-period input, back-to-back streaming and a ROUNDS=4 instance.

module tb_gimli_permutation_iterative;

`ifdef GIMLI_PERMUTATION_TWO_ROUNDS_PER_CYCLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int LAT  = 24 / STEP;
  localparam int LAT4 = 4 / STEP;

  localparam logic [383:0] PAPER_OUT = {
    32'hf41bb8d6, 32'h9e2bef49, 32'h34e52ff7, 32'h84b673f0,
    32'hda5a9cd8, 32'h4f73a0bd, 32'h277a921c, 32'h3eceffea,
    32'hd24c2c68, 32'h380ce880, 32'h91bad119, 32'hba11c85a};

  logic         clk = 1'b0;
  logic         rst;
  logic [383:0] din, dout;
  logic         din_valid, din_ready, dout_valid, dout_ready;
  logic [383:0] din4, dout4;
  logic         din4_valid, din4_ready, dout4_valid, dout4_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [383:0] paper_in;
  logic [383:0] zref;
  logic [383:0] zref4;

  always #5 clk = ~clk;

  gimli_permutation_iterative u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  gimli_permutation_iterative #(.ROUNDS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .din        (din4),
    .din_valid  (din4_valid),
    .din_ready  (din4_ready),
    .dout       (dout4),
    .dout_valid (dout4_valid),
    .dout_ready (dout4_ready)
  );

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference Gimli, written from the published C description.
  function automatic logic [383:0] gimli_ref(input logic [383:0] in, input int rounds);
    logic [31:0] s [12];
    logic [31:0] x, y, z, t;
    logic [383:0] o;
    for (int i = 0; i < 12; i++) s[i] = in[32*i +: 32];
    for (int r = rounds; r > 0; r--) begin
      for (int j = 0; j < 4; j++) begin
        x = (s[j] << 24) | (s[j] >> 8);
        y = (s[4+j] << 9) | (s[4+j] >> 23);
        z = s[8+j];
        s[8+j] = x ^ (z << 1) ^ ((y & z) << 2);
        s[4+j] = y ^ x ^ ((x | z) << 1);
        s[j]   = z ^ y ^ ((x & y) << 3);
      end
      if ((r & 3) == 0) begin
        t = s[0]; s[0] = s[1]; s[1] = t;
        t = s[2]; s[2] = s[3]; s[3] = t;
        s[0] = s[0] ^ 32'h9e377900 ^ 32'(r);
      end
      if ((r & 3) == 2) begin
        t = s[0]; s[0] = s[2]; s[2] = t;
        t = s[1]; s[1] = s[3]; s[3] = t;
      end
    end
    for (int i = 0; i < 12; i++) o[32*i +: 32] = s[i];
    return o;
  endfunction

  task automatic accept(input logic [383:0] v);
    @(negedge clk);
    chk("accept_din_ready", 384'(din_ready), 384'(1'b1));
    din       = v;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!dout_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_reached", 384'(dout_valid), 384'(1'b1));
  endtask

  task automatic release_out();
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("release_din_ready", 384'(din_ready), 384'(1'b1));
    chk("release_dout_valid", 384'(dout_valid), 384'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, e, last, seen, stay;
    logic [31:0] iv;
    bit check_idle;

    for (int i = 0; i < 12; i++) begin
      iv = 32'(i);
      paper_in[32*i +: 32] = iv * iv * iv + iv * 32'h9e3779b9;
    end
    zref  = gimli_ref(384'd0, 24);
    zref4 = gimli_ref(384'd0, 4);

    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    din4 = '0; din4_valid = 1'b0; dout4_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_din_ready", 384'(din_ready), 384'(1'b1));
    chk("reset_dout_valid", 384'(dout_valid), 384'(1'b0));
    chk("reset_dout", dout, 384'd0);
    rst = 1'b0;

    // Paper vector and latency
    accept(paper_in);
    wait_done(c);
    chk("paper_latency", 384'(c), 384'(LAT));
    chk("paper_dout", dout, PAPER_OUT);

    // Downstream stall
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("stall_dout_valid", 384'(dout_valid), 384'(1'b1));
      chk("stall_dout", dout, PAPER_OUT);
      chk("stall_din_ready", 384'(din_ready), 384'(1'b0));
    end
    release_out();

    // Reset mid-operation
    accept(paper_in);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_din_ready", 384'(din_ready), 384'(1'b1));
    chk("midrst_dout_valid", 384'(dout_valid), 384'(1'b0));
    chk("midrst_dout", dout, 384'd0);
    rst = 1'b0;
    accept(paper_in);
    wait_done(c);
    chk("after_rst_w0", 384'(dout[31:0]), 384'(32'hba11c85a));
    release_out();

    // Input activity while BUSY and DONE
    accept(paper_in);
    stay = 0;
    c = 0;
    while (stay < 5 && c < 200) begin
      @(negedge clk);
      for (int k = 0; k < 12; k++) din[32*k +: 32] = $urandom;
      din_valid = ~din_valid;
      if (dout_valid) stay++;
      c++;
    end
    din_valid = 1'b0;
    chk("busy_in_dout_valid", 384'(dout_valid), 384'(1'b1));
    chk("busy_in_dout", dout, PAPER_OUT);
    release_out();

    // Back-to-back all-zero input with both handshakes held high
    @(negedge clk);
    din = '0; din_valid = 1'b1; dout_ready = 1'b1;
    e = 0; last = -1; seen = 0; check_idle = 1'b0;
    while (seen < 3 && e < 300) begin
      @(posedge clk);
      #1;
      e++;
      if (check_idle) begin
        chk("b2b_idle_din_ready", 384'(din_ready), 384'(1'b1));
        chk("b2b_idle_dout_valid", 384'(dout_valid), 384'(1'b0));
        check_idle = 1'b0;
      end
      if (dout_valid) begin
        chk("b2b_dout", dout, zref);
        if (last >= 0) chk("b2b_period", 384'(e - last), 384'(LAT + 2));
        last = e;
        seen++;
        check_idle = 1'b1;
      end
    end
    chk("b2b_count", 384'(seen), 384'(3));
    @(negedge clk);
    din_valid = 1'b0; dout_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // ROUNDS=4 instance exercises the round-constant 9e377904 path
    @(negedge clk);
    chk("r4_din_ready", 384'(din4_ready), 384'(1'b1));
    din4 = '0; din4_valid = 1'b1;
    @(posedge clk);
    #1;
    din4_valid = 1'b0;
    c = 0;
    while (!dout4_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("r4_latency", 384'(c), 384'(LAT4));
    chk("r4_dout", dout4, zref4);
    chk("r4_w0", 384'(dout4[31:0]), 384'(zref4[31:0]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
